// File: rtl/div_sequencer.sv
// div_sequencer
//   Multi-cycle integer divide/remainder sequencer for the execute stage.
//   A radix-2 restoring iteration produces one quotient bit per cycle.
//   Divide-by-zero and signed overflow take a two-cycle fast path.
//   The pipeline stall request is held while an operation is in flight.
//   A one-cycle done pulse delivers the result and the destination index.
//
// Parameters
//   XLEN  operand/result width (>= 2)
//   RD_W  destination register index width
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request, sampled only in IDLE
//   op         in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b       in   dividend, divisor
//   rd_in      in   destination index, captured with start
//   flush      in   abort any in-flight operation
//   busy       out  high in CALC and DONE
//   stall_req  out  freeze request for the upstream stage
//   done       out  one-cycle result-valid pulse
//   result     out  quotient or remainder, held until the next completion
//   rd_out     out  destination index, held with result
module div_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [RD_W-1:0] rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FAST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [RD_W-1:0] rd_q;
  logic            neg_q;
  logic            neg_r;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] bmag_q;
  logic [XLEN-1:0] fast_q;

  // Accept-side decode
  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            b_zero;
  logic            ovf;
  logic            accept;
  logic [XLEN-1:0] fast_val;

  // Iteration datapath
  logic [XLEN-1:0] shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] final_val;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = a[XLEN-1];
    b_neg     = b[XLEN-1];
    a_mag     = (signed_op && a_neg) ? -a : a;
    b_mag     = (signed_op && b_neg) ? -b : b;
    b_zero    = (b == '0);
    ovf       = signed_op && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    accept    = start && !flush && (state == S_IDLE);
    // Divide-by-zero returns the raw dividend as remainder, not its magnitude.
    if (b_zero) begin
      fast_val = op[1] ? a : '1;
    end else begin
      fast_val = op[1] ? '0 : a;
    end
  end

  always_comb begin
    shifted = {rem[XLEN-2:0], quo[XLEN-1]};
    diff    = {1'b0, shifted} - {1'b0, bmag_q};
    rem_nxt = diff[XLEN] ? shifted : diff[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], ~diff[XLEN]};
    // The final result is formed from this cycle's next values so it lands
    // on the same edge as the last iteration.
    if (op_q[1]) begin
      final_val = neg_r ? -rem_nxt : rem_nxt;
    end else begin
      final_val = neg_q ? -quo_nxt : quo_nxt;
    end
  end

  always_comb begin
    busy      = (state == S_CALC) || (state == S_DONE);
    done      = (state == S_DONE);
    stall_req = accept || (state == S_CALC) || (state == S_FAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= '0;
      rd_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      bmag_q <= '0;
      fast_q <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= op;
            rd_q   <= rd_in;
            neg_q  <= signed_op && (a_neg ^ b_neg);
            neg_r  <= signed_op && a_neg;
            cnt    <= '0;
            rem    <= '0;
            quo    <= a_mag;
            bmag_q <= b_mag;
            fast_q <= fast_val;
            state  <= (b_zero || ovf) ? S_FAST : S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN - 1)) begin
              result <= final_val;
              rd_out <= rd_q;
              state  <= S_DONE;
            end
          end
        end
        // Fast results are staged until here so a flush leaves the
        // visible result untouched.
        S_FAST: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            result <= fast_q;
            rd_out <= rd_q;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
